// File: rtl/ndn_name_streamer.sv
// Name-component feeder for the FIB lookup pipeline: buffers whole NDN names
// arriving word-serial and replays them one component per word.
module ndn_name_streamer #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int NAME_DEPTH      = 8,
  parameter int IDX_SIZE        = 3,
  parameter int GAP_SIZE        = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [WORD_SIZE-1:0]        in_word,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [WORD_SIZE-1:0]        out_word,
  output logic                        out_valid,
  output logic                        out_first,
  output logic                        out_last,
  output logic [IDX_SIZE-1:0]         out_index,
  input  logic                        out_ready,
  input  logic [GAP_SIZE-1:0]         gap_cycles_in,
  output logic [$clog2(NAME_DEPTH):0] names_pending,
  output logic                        overflow_err
);

  localparam int SW = $clog2(NAME_DEPTH);
  localparam int PW = SW + 1;
  localparam int LW = IDX_SIZE + 1;
  localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_NAME_LENGTH);
  localparam logic [PW-1:0] FULL_CNT = PW'(NAME_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [WORD_SIZE-1:0] mem_r [NAME_DEPTH][MAX_NAME_LENGTH];
  logic [LW-1:0]        len_r [NAME_DEPTH];

  logic [SW-1:0]        wr_slot_r;
  logic [LW-1:0]        wr_idx_r;
  logic [SW-1:0]        rd_slot_r;
  logic [IDX_SIZE-1:0]  rd_idx_r;
  logic [GAP_SIZE-1:0]  gap_cnt_r;
  state_t               state_r;

  logic                 wr_fire_s;
  logic                 commit_s;
  logic                 release_s;
  logic                 wr_keep_s;
  logic [LW-1:0]        commit_len_s;
  logic [PW-1:0]        pending_nxt_s;
  logic [SW-1:0]        nxt_slot_s;
  logic [IDX_SIZE-1:0]  nxt_idx_s;
  logic                 more_s;
  logic [SW-1:0]        ld_slot_s;
  logic [IDX_SIZE-1:0]  ld_idx_s;
  logic [WORD_SIZE-1:0] ld_word_s;
  logic [LW-1:0]        ld_len_s;
  logic                 ld_last_s;

  assign wr_fire_s = in_valid && in_ready;
  assign commit_s  = wr_fire_s && in_last;
  assign release_s = (state_r == SEND) && out_ready && out_last;
  // Words past MAX_NAME_LENGTH are swallowed; the index saturates at MAX_LEN.
  assign wr_keep_s = (wr_idx_r < MAX_LEN);

  // Commit length and pending-count update
  always_comb begin
    commit_len_s  = MAX_LEN;
    pending_nxt_s = names_pending;
    if (wr_keep_s) begin
      commit_len_s = wr_idx_r + LW'(1);
    end else begin
      commit_len_s = MAX_LEN;
    end
    case ({commit_s, release_s})
      2'b10:   pending_nxt_s = names_pending + PW'(1);
      2'b01:   pending_nxt_s = names_pending - PW'(1);
      default: pending_nxt_s = names_pending;
    endcase
  end

  // Read pointer advance after an accepted output word
  always_comb begin
    nxt_slot_s = rd_slot_r;
    nxt_idx_s  = rd_idx_r;
    more_s     = 1'b0;
    if (out_last) begin
      nxt_slot_s = rd_slot_r + SW'(1);
      nxt_idx_s  = IDX_SIZE'(0);
      more_s     = (names_pending != PW'(1));
    end else begin
      nxt_slot_s = rd_slot_r;
      nxt_idx_s  = rd_idx_r + IDX_SIZE'(1);
      more_s     = 1'b1;
    end
  end

  // Select the word the FSM loads into the output registers
  always_comb begin
    ld_slot_s = rd_slot_r;
    ld_idx_s  = IDX_SIZE'(0);
    case (state_r)
      IDLE: begin
        ld_slot_s = rd_slot_r;
        ld_idx_s  = IDX_SIZE'(0);
      end
      SEND: begin
        ld_slot_s = nxt_slot_s;
        ld_idx_s  = nxt_idx_s;
      end
      GAP: begin
        ld_slot_s = rd_slot_r;
        ld_idx_s  = rd_idx_r;
      end
      default: begin
        ld_slot_s = rd_slot_r;
        ld_idx_s  = IDX_SIZE'(0);
      end
    endcase
    ld_word_s = mem_r[ld_slot_s][ld_idx_s];
    ld_len_s  = len_r[ld_slot_s];
    ld_last_s = ({1'b0, ld_idx_s} == (ld_len_s - LW'(1)));
  end

  // Name storage and per-slot length
  always_ff @(posedge clk_in) begin
    if (wr_fire_s && wr_keep_s) begin
      mem_r[wr_slot_r][wr_idx_r[IDX_SIZE-1:0]] <= in_word;
    end
    if (commit_s) begin
      len_r[wr_slot_r] <= commit_len_s;
    end
  end

  // Write pointers, pending count, input ready and sticky overflow
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_slot_r     <= SW'(0);
      wr_idx_r      <= LW'(0);
      names_pending <= PW'(0);
      in_ready      <= 1'b1;
      overflow_err  <= 1'b0;
    end else begin
      names_pending <= pending_nxt_s;
      in_ready      <= (pending_nxt_s != FULL_CNT);
      if (wr_fire_s) begin
        if (in_last) begin
          wr_slot_r <= wr_slot_r + SW'(1);
          wr_idx_r  <= LW'(0);
        end else if (wr_keep_s) begin
          wr_idx_r  <= wr_idx_r + LW'(1);
        end else begin
          wr_idx_r  <= wr_idx_r;
        end
        if (!wr_keep_s) begin
          overflow_err <= 1'b1;
        end
      end
    end
  end

  // Read FSM with registered output word and flags
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= IDLE;
      rd_slot_r <= SW'(0);
      rd_idx_r  <= IDX_SIZE'(0);
      gap_cnt_r <= GAP_SIZE'(0);
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_index <= IDX_SIZE'(0);
      out_word  <= WORD_SIZE'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (names_pending != PW'(0)) begin
            state_r   <= SEND;
            rd_idx_r  <= IDX_SIZE'(0);
            out_valid <= 1'b1;
            out_word  <= ld_word_s;
            out_index <= ld_idx_s;
            out_first <= (ld_idx_s == IDX_SIZE'(0));
            out_last  <= ld_last_s;
          end
        end
        SEND: begin
          if (out_ready) begin
            rd_slot_r <= nxt_slot_s;
            rd_idx_r  <= nxt_idx_s;
            if (gap_cycles_in != GAP_SIZE'(0)) begin
              gap_cnt_r <= gap_cycles_in;
              state_r   <= GAP;
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
            end else if (more_s) begin
              out_word  <= ld_word_s;
              out_index <= ld_idx_s;
              out_first <= (ld_idx_s == IDX_SIZE'(0));
              out_last  <= ld_last_s;
            end else begin
              state_r   <= IDLE;
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        GAP: begin
          gap_cnt_r <= gap_cnt_r - GAP_SIZE'(1);
          if (gap_cnt_r <= GAP_SIZE'(1)) begin
            // A mid-name gap always has its own name still counted as pending.
            if (names_pending != PW'(0)) begin
              state_r   <= SEND;
              out_valid <= 1'b1;
              out_word  <= ld_word_s;
              out_index <= ld_idx_s;
              out_first <= (ld_idx_s == IDX_SIZE'(0));
              out_last  <= ld_last_s;
            end else begin
              state_r   <= IDLE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          out_first <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ndn_name_streamer.sv
// Directed bench for ndn_name_streamer: reset, throughput, cadence, full,
// overflow, latency and back-pressure scenarios with a word monitor.
module tb_ndn_name_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_word;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_word;
  logic        out_valid, out_first, out_last, out_ready;
  logic [2:0]  out_index;
  logic [3:0]  gap_cycles;
  logic [3:0]  names_pending;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mw_q[$];
  logic        mf_q[$];
  logic        ml_q[$];
  logic [2:0]  mi_q[$];
  int          mc_q[$];

  ndn_name_streamer dut (
    .clk_in(clk), .rst_n_in(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_word(out_word),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .out_index(out_index), .out_ready(out_ready), .gap_cycles_in(gap_cycles),
    .names_pending(names_pending), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every word that will be accepted at the coming rising edge
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mw_q.push_back(out_word);
      mf_q.push_back(out_first);
      ml_q.push_back(out_last);
      mi_q.push_back(out_index);
      mc_q.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_name(input logic [31:0] base, input int n, input bit do_last);
    for (int i = 0; i < n; i++) begin
      bit acc = 1'b0;
      int t = 0;
      in_word  = base + 32'(i);
      in_valid = 1'b1;
      in_last  = do_last && (i == n - 1);
      while (!acc && t < 300) begin
        acc = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        errors++;
        $display("FAIL write_timeout: word %h not accepted, got in_ready=%b required 1", in_word, in_ready);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    int t = 0;
    while (mw_q.size() < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (mw_q.size() >= n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_word = 32'h0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; gap_cycles = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (names_pending !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d required 0", names_pending); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow_err); end
    checks++; if ({out_word, out_index, out_first, out_last} !== 37'h0) begin
      errors++; $display("FAIL reset_out_fields: got word=%h idx=%0d first=%b last=%b required all 0", out_word, out_index, out_first, out_last);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int s;
    out_ready = 1'b0;
    write_name(32'h1000_0000, 2, 1'b1);
    write_name(32'h2000_0000, 5, 1'b0);
    checks++; if (out_valid !== 1'b1 || names_pending !== 4'd1) begin
      errors++; $display("FAIL mid_pre_state: got valid=%b pending=%0d required 1/1", out_valid, names_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_word !== 32'h0) begin
      errors++; $display("FAIL mid_reset_out: got valid=%b word=%h required 0/0", out_valid, out_word);
    end
    checks++; if (names_pending !== 4'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_ctrl: got pending=%0d in_ready=%b required 0/1", names_pending, in_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    s = mw_q.size();
    out_ready = 1'b1;
    write_name(32'h3000_0000, 8, 1'b1);
    wait_words(s + 8, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_after_timeout: got %0d words required 8", mw_q.size() - s); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (mw_q[s+i] !== 32'h3000_0000 + 32'(i) || mi_q[s+i] !== 3'(i)) begin
          errors++; $display("FAIL mid_after_word%0d: got %h idx %0d required %h idx %0d", i, mw_q[s+i], mi_q[s+i], 32'h3000_0000 + 32'(i), i);
        end
      end
    end
  endtask

  task automatic test_throughput;
    bit ok;
    int s;
    out_ready = 1'b0;
    gap_cycles = 4'd0;
    for (int k = 0; k < 8; k++) write_name(32'hA000_0000 + 32'(k) * 32'd256, 8, 1'b1);
    checks++; if (names_pending !== 4'd8 || in_ready !== 1'b0) begin
      errors++; $display("FAIL tp_full: got pending=%0d in_ready=%b required 8/0", names_pending, in_ready);
    end
    s = mw_q.size();
    out_ready = 1'b1;
    wait_words(s + 64, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tp_timeout: got %0d words required 64", mw_q.size() - s); end
    else begin
      for (int i = 0; i < 64; i++) begin
        logic [31:0] ew;
        ew = 32'hA000_0000 + 32'(i / 8) * 32'd256 + 32'(i % 8);
        checks++;
        if (mw_q[s+i] !== ew || mf_q[s+i] !== (i % 8 == 0) || ml_q[s+i] !== (i % 8 == 7) || mi_q[s+i] !== 3'(i % 8)) begin
          errors++; $display("FAIL tp_word%0d: got %h f=%b l=%b idx=%0d required %h f=%b l=%b idx=%0d",
                             i, mw_q[s+i], mf_q[s+i], ml_q[s+i], mi_q[s+i], ew, (i % 8 == 0), (i % 8 == 7), i % 8);
        end
      end
      checks++; if (mc_q[s+63] - mc_q[s] !== 63) begin
        errors++; $display("FAIL tp_cadence: got span %0d clocks required 63", mc_q[s+63] - mc_q[s]);
      end
    end
  endtask

  task automatic test_full;
    bit ok;
    int s;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) write_name(32'hC000_0000 + 32'(k), 1, 1'b1);
    checks++; if (names_pending !== 4'd8 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: got pending=%0d in_ready=%b required 8/0", names_pending, in_ready);
    end
    s = mw_q.size();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (names_pending !== 4'd7 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_release: got pending=%0d in_ready=%b required 7/1", names_pending, in_ready);
    end
    out_ready = 1'b1;
    wait_words(s + 8, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got %0d words required 8", mw_q.size() - s); end
    else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (mw_q[s+k] !== 32'hC000_0000 + 32'(k) || ml_q[s+k] !== 1'b1 || mf_q[s+k] !== 1'b1) begin
          errors++; $display("FAIL full_order%0d: got %h f=%b l=%b required %h f=1 l=1", k, mw_q[s+k], mf_q[s+k], ml_q[s+k], 32'hC000_0000 + 32'(k));
        end
      end
    end
  endtask

  task automatic test_latency;
    out_ready = 1'b0;
    write_name(32'hE000_0000, 1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_edge_e: got out_valid=%b required 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_word !== 32'hE000_0000 || out_first !== 1'b1 || out_last !== 1'b1 || out_index !== 3'd0) begin
      errors++; $display("FAIL lat_edge_e1: got v=%b w=%h f=%b l=%b i=%0d required 1 e0000000 1 1 0", out_valid, out_word, out_first, out_last, out_index);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (names_pending !== 4'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_drain: got pending=%0d valid=%b required 0/0", names_pending, out_valid);
    end
  endtask

  task automatic test_cadence;
    bit ok;
    int s;
    gap_cycles = 4'd1;
    out_ready = 1'b1;
    s = mw_q.size();
    write_name(32'h5000_0000, 8, 1'b1);
    wait_words(s + 8, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cad_timeout: got %0d words required 8", mw_q.size() - s); end
    else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (mc_q[s+i] - mc_q[s+i-1] !== 2 || mw_q[s+i] !== 32'h5000_0000 + 32'(i)) begin
          errors++; $display("FAIL cad_word%0d: got %h after %0d clocks required %h after 2", i, mw_q[s+i], mc_q[s+i] - mc_q[s+i-1], 32'h5000_0000 + 32'(i));
        end
      end
      checks++; if (mc_q[s+7] - mc_q[s] + 1 !== 15) begin
        errors++; $display("FAIL cad_span: got %0d clocks required 15", mc_q[s+7] - mc_q[s] + 1);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    gap_cycles = 4'd0;
  endtask

  task automatic test_overflow;
    bit ok;
    int s;
    out_ready = 1'b1;
    s = mw_q.size();
    write_name(32'hD000_0000, 8, 1'b0);
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b required 0", overflow_err); end
    write_name(32'hD000_0008, 2, 1'b1);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow_err); end
    wait_words(s + 8, 30, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (!ok || mw_q.size() !== s + 8) begin
      errors++; $display("FAIL ovf_count: got %0d words required 8", mw_q.size() - s);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (mw_q[s+i] !== 32'hD000_0000 + 32'(i) || ml_q[s+i] !== (i == 7)) begin
          errors++; $display("FAIL ovf_word%0d: got %h l=%b required %h l=%b", i, mw_q[s+i], ml_q[s+i], 32'hD000_0000 + 32'(i), (i == 7));
        end
      end
    end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow_err); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int s;
    int lens[4] = '{3, 1, 5, 2};
    logic [31:0] exp_q[$];
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < lens[n]; i++) exp_q.push_back(32'hF000_0000 + 32'(n) * 32'd256 + 32'(i));
    s = mw_q.size();
    fork
      begin
        for (int n = 0; n < 4; n++) write_name(32'hF000_0000 + 32'(n) * 32'd256, lens[n], 1'b1);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_words(s + 11, 40, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (!ok || mw_q.size() !== s + 11) begin
      errors++; $display("FAIL bp_count: got %0d words required 11", mw_q.size() - s);
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (mw_q[s+i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %h required %h", i, mw_q[s+i], exp_q[i]); end
      end
    end
    // Commit of one name on the same edge as the release of another
    out_ready = 1'b0;
    s = mw_q.size();
    write_name(32'h6000_0000, 1, 1'b1);
    write_name(32'h6100_0000, 1, 1'b0);
    checks++; if (names_pending !== 4'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL sim_pre: got pending=%0d valid=%b required 1/1", names_pending, out_valid);
    end
    in_word = 32'h6100_0001; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (names_pending !== 4'd1) begin errors++; $display("FAIL sim_pending: got %0d required 1", names_pending); end
    wait_words(s + 3, 20, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (!ok || mw_q.size() !== s + 3 || mw_q[s] !== 32'h6000_0000 || mw_q[s+1] !== 32'h6100_0000 || mw_q[s+2] !== 32'h6100_0001) begin
      errors++; $display("FAIL sim_words: got %0d words, first %h required 3 words 60000000 61000000 61000001", mw_q.size() - s, (mw_q.size() > s) ? mw_q[s] : 32'h0);
    end
  endtask

  task automatic test_final_reset;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (overflow_err !== 1'b0 || names_pending !== 4'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL final_reset: got ovf=%b pending=%0d in_ready=%b required 0/0/1", overflow_err, names_pending, in_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_throughput();
    test_full();
    test_latency();
    test_cadence();
    test_overflow();
    test_back_to_back();
    test_final_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
